store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart to the load/immediate widening path in the multi-cycle MIPS datapath.
- Narrows SB/SH/SW register data into a word-only data memory.
- Sub-word stores use a read-modify-write: read the word, merge the byte or halfword lane, write the word back.
- Sits between the store-issue control state and the data memory. Raises a one-cycle done so the main FSM can advance.

Parameters:
- ADDR_WIDTH, 32, width of byte address and memory word address bus
- TIMEOUT, 255, max cycles to wait for mem_ready in any memory phase before aborting (must be >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  request pulse; sampled only in IDLE
- addr  input  ADDR_WIDTH  byte address of store
- wdata  input  32  register data; low bits hold the byte/halfword
- size  input  2  00=byte, 01=halfword, 10=word, 11=illegal
- mem_addr  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
- mem_re  output  1  read request, held until mem_ready
- mem_we  output  1  write request, held until mem_ready
- mem_wdata  output  32  merged write word
- mem_rdata  input  32  read data, valid when mem_ready=1 during READ
- mem_ready  input  1  memory accepts/completes current request this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, on misalign/illegal/timeout

Behaviour:
- All outputs registered. Reset values: mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0. State=IDLE, timeout counter=0.
- Lane mapping is little-endian: byte k occupies bits [8k+7:8k], k=addr[1:0]. Halfword at addr[1]=h occupies bits [16h+15:16h].
- States: IDLE, READ, WRITE, FINISH.
- IDLE, start=1: latch addr, wdata, size.
  - Illegal case (size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0): go to FINISH with err flagged. No memory access.
  - size=10: go to WRITE with mem_wdata=wdata.
  - Otherwise: go to READ.
- start while busy: ignored; no queuing.
- READ: mem_re=1 with stable mem_addr. On the mem_ready cycle, capture mem_rdata and build the merged word (unselected lanes from mem_rdata, selected lane from wdata low bits). Next cycle is WRITE with mem_re=0 and mem_we=1.
- WRITE: mem_we=1 with stable mem_addr/mem_wdata. On mem_ready, go to FINISH with mem_we=0.
- FINISH: done=1 (err=1 if flagged) for exactly one cycle, then IDLE; busy=0 from that IDLE cycle.
- Latency with ready tied high:
  - word store: done 3 cycles after the start edge
  - sub-word store: done 4 cycles after the start edge
  - illegal request: done 2 cycles after the start edge
- mem_re and mem_we are never high in the same cycle.
- Timeout: counter clears on entry to READ/WRITE and increments each cycle without mem_ready. Reaching TIMEOUT drops mem_re/mem_we and goes to FINISH with err. If mem_ready arrives on the TIMEOUT cycle, mem_ready wins.
- Reset mid-operation: next edge forces IDLE, with mem_re/mem_we/done/err=0. An in-flight write may be abandoned.
- mem_rdata is ignored outside READ; mem_ready is ignored in IDLE and FINISH.

Test Plan:
- Word store, ready tied 1: addr=0x100, wdata=0xDEADBEEF, size=10 -> no mem_re; one mem_we cycle with mem_addr=0x100, mem_wdata=0xDEADBEEF; done 3 cycles after start; err=0.
- Byte store: addr=0x0000_0102, wdata=0x0000_00AB, size=00, mem_rdata=0x11223344 -> mem_re then mem_we at 0x100, mem_wdata=0x11AB3344; done at cycle 4.
- Halfword store with a 3-cycle ready delay on each phase: addr=0x202, wdata=0x0000_CAFE, mem_rdata=0x55667788 -> mem_re held 3 cycles, then mem_wdata=0xCAFE7788; done once.
- Misaligned/illegal: size=01 addr=0x201; size=10 addr=0x202; size=11 -> err=done=1 at cycle 2; mem_re and mem_we never asserted.
- Timeout with TIMEOUT=4, mem_ready stuck 0 -> mem_re drops after 4 cycles in READ; err and done pulse; block back in IDLE; a second start is then accepted.
- Reset asserted during WRITE and a start pulse during busy -> after reset, outputs at reset values next cycle; a start pulse while busy produces no extra done.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Narrows SB/SH/SW register data into a word-only data memory. Word stores
// are a single write. Byte and halfword stores read the containing word,
// replace one lane, and write the word back. One cycle after the operation
// finishes, done pulses for one cycle, together with err if the request was
// illegal or a memory phase timed out.
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [1:0]            size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    // The counter value on the last cycle a phase may wait before it aborts.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;        // addr[1:0] of the store
    logic                    is_half_q, is_half_d;  // sub-word store is a halfword
    logic [15:0]             sub_q, sub_d;          // low bits of register data
    logic                    err_flag_q, err_flag_d;
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_re_q, mem_re_d;
    logic                    mem_we_q, mem_we_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    illegal_req;
    logic                    timeout_hit;
    logic [31:0]             merged_word;

    // A request is illegal when the size code is reserved or the address is
    // not naturally aligned for the access size.
    assign illegal_req = (size == 2'b11)
                      || ((size == 2'b01) && addr[0])
                      || ((size == 2'b10) && (addr[1:0] != 2'b00));

    assign timeout_hit = (tmo_cnt_q == TMO_LAST);

    // Per-lane merge: the selected byte lane(s) take register data, the rest
    // keep what was read from memory. Lanes are little-endian.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_sel;
            logic [7:0] src_byte;
            assign lane_sel = is_half_q ? (lane_q[1] == LANE[1]) : (lane_q == LANE);
            assign src_byte = (is_half_q && LANE[0]) ? sub_q[15:8] : sub_q[7:0];
            assign merged_word[8*gi +: 8] = lane_sel ? src_byte : mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        is_half_d   = is_half_q;
        sub_d       = sub_q;
        err_flag_d  = err_flag_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lane_d     = addr[1:0];
                    is_half_d  = size[0];
                    sub_d      = wdata[15:0];
                    mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                    tmo_cnt_d  = '0;
                    err_flag_d = 1'b0;
                    if (illegal_req) begin
                        err_flag_d = 1'b1;
                        state_d    = FINISH;
                    end else if (size == 2'b10) begin
                        mem_wdata_d = wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (mem_ready) begin
                    mem_wdata_d = merged_word;
                    tmo_cnt_d   = '0;
                    state_d     = WRITE;
                end else if (timeout_hit) begin
                    err_flag_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_d = FINISH;
                end else if (timeout_hit) begin
                    err_flag_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                err_d   = err_flag_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request strobes follow the state being entered, so they are
        // mutually exclusive by construction.
        mem_re_d = (state_d == READ);
        mem_we_d = (state_d == WRITE);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            is_half_q   <= 1'b0;
            sub_q       <= '0;
            err_flag_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            is_half_q   <= is_half_d;
            sub_q       <= sub_d;
            err_flag_q  <= err_flag_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed testbench for store_merge_unit (TIMEOUT overridden to 4).
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    // Running event counts, sampled at each rising edge.
    int done_cnt    = 0;
    int re_cnt      = 0;
    int we_cnt      = 0;
    int overlap_cnt = 0;
    int snap_done, snap_re, snap_we;

    always #5 clk = ~clk;

    store_merge_unit #(
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .wdata    (wdata),
        .size     (size),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_re === 1'b1) re_cnt++;
        if (mem_we === 1'b1) we_cnt++;
        if (mem_re === 1'b1 && mem_we === 1'b1) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
            $display("ok   %-22s observed=%08h expected=%08h", tag, obs, exp);
        else begin
            n_miss++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        start = 1'b1;
        addr  = a;
        wdata = d;
        size  = s;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);

        // Word store, ready tied high: done 3 cycles after start edge
        mem_ready = 1'b1;
        snap_re = re_cnt; snap_we = we_cnt;
        issue(32'h100, 32'hDEADBEEF, 2'b10);                       // edge 1
        chk("sw_we_c1", {31'b0, mem_we}, 32'h1);
        chk("sw_re_c1", {31'b0, mem_re}, 32'h0);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_busy_c1", {31'b0, busy}, 32'h1);
        tick();                                                     // edge 2
        chk("sw_we_c2", {31'b0, mem_we}, 32'h0);
        chk("sw_done_c2", {31'b0, done}, 32'h0);
        tick();                                                     // edge 3
        chk("sw_done_c3", {31'b0, done}, 32'h1);
        chk("sw_err_c3", {31'b0, err}, 32'h0);
        chk("sw_busy_c3", {31'b0, busy}, 32'h0);
        tick();
        chk("sw_done_c4", {31'b0, done}, 32'h0);
        chk("sw_re_total", re_cnt - snap_re, 32'd0);
        chk("sw_we_total", we_cnt - snap_we, 32'd1);

        // Byte store at lane 2
        mem_rdata = 32'h11223344;
        issue(32'h102, 32'h000000AB, 2'b00);                       // edge 1
        chk("sb_re_c1", {31'b0, mem_re}, 32'h1);
        chk("sb_we_c1", {31'b0, mem_we}, 32'h0);
        chk("sb_addr", mem_addr, 32'h100);
        tick();                                                     // edge 2
        chk("sb_re_c2", {31'b0, mem_re}, 32'h0);
        chk("sb_we_c2", {31'b0, mem_we}, 32'h1);
        chk("sb_wdata", mem_wdata, 32'h11AB3344);
        tick();                                                     // edge 3
        chk("sb_done_c3", {31'b0, done}, 32'h0);
        tick();                                                     // edge 4
        chk("sb_done_c4", {31'b0, done}, 32'h1);
        chk("sb_err_c4", {31'b0, err}, 32'h0);
        tick();

        // Halfword store, 3-cycle ready delay on each phase
        mem_ready = 1'b0;
        mem_rdata = 32'h55667788;
        snap_done = done_cnt;
        issue(32'h202, 32'h0000CAFE, 2'b01);                       // edge 1
        chk("sh_re_c1", {31'b0, mem_re}, 32'h1);
        chk("sh_addr", mem_addr, 32'h200);
        tick();                                                     // edge 2
        chk("sh_re_c2", {31'b0, mem_re}, 32'h1);
        tick();                                                     // edge 3
        chk("sh_re_c3", {31'b0, mem_re}, 32'h1);
        mem_ready = 1'b1;
        tick();                                                     // edge 4
        mem_ready = 1'b0;
        chk("sh_re_c4", {31'b0, mem_re}, 32'h0);
        chk("sh_we_c4", {31'b0, mem_we}, 32'h1);
        chk("sh_wdata", mem_wdata, 32'hCAFE7788);
        tick();                                                     // edge 5
        chk("sh_we_c5", {31'b0, mem_we}, 32'h1);
        tick();                                                     // edge 6
        chk("sh_we_c6", {31'b0, mem_we}, 32'h1);
        mem_ready = 1'b1;
        tick();                                                     // edge 7
        mem_ready = 1'b0;
        chk("sh_we_c7", {31'b0, mem_we}, 32'h0);
        chk("sh_done_c7", {31'b0, done}, 32'h0);
        tick();                                                     // edge 8
        chk("sh_done_c8", {31'b0, done}, 32'h1);
        chk("sh_err_c8", {31'b0, err}, 32'h0);
        tick(); tick();
        chk("sh_done_once", done_cnt - snap_done, 32'd1);

        // Illegal requests: misaligned halfword, misaligned word, size 11
        mem_ready = 1'b1;
        snap_re = re_cnt; snap_we = we_cnt;
        issue(32'h201, 32'h1234, 2'b01);
        chk("il_h_busy_c1", {31'b0, busy}, 32'h1);
        chk("il_h_done_c1", {31'b0, done}, 32'h0);
        tick();
        chk("il_h_done_c2", {31'b0, done}, 32'h1);
        chk("il_h_err_c2", {31'b0, err}, 32'h1);
        issue(32'h202, 32'h5678, 2'b10);
        chk("il_w_done_c1", {31'b0, done}, 32'h0);
        tick();
        chk("il_w_done_c2", {31'b0, done}, 32'h1);
        chk("il_w_err_c2", {31'b0, err}, 32'h1);
        issue(32'h300, 32'h9ABC, 2'b11);
        chk("il_s_done_c1", {31'b0, done}, 32'h0);
        tick();
        chk("il_s_done_c2", {31'b0, done}, 32'h1);
        chk("il_s_err_c2", {31'b0, err}, 32'h1);
        tick();
        chk("il_re_total", re_cnt - snap_re, 32'd0);
        chk("il_we_total", we_cnt - snap_we, 32'd0);

        // Timeout in READ with ready stuck low (TIMEOUT=4)
        mem_ready = 1'b0;
        issue(32'h300, 32'h77, 2'b00);                             // edge 1
        chk("to_re_c1", {31'b0, mem_re}, 32'h1);
        tick(); tick(); tick();                                     // edge 4
        chk("to_re_c4", {31'b0, mem_re}, 32'h1);
        tick();                                                     // edge 5
        chk("to_re_c5", {31'b0, mem_re}, 32'h0);
        chk("to_we_c5", {31'b0, mem_we}, 32'h0);
        chk("to_busy_c5", {31'b0, busy}, 32'h1);
        tick();                                                     // edge 6
        chk("to_done_c6", {31'b0, done}, 32'h1);
        chk("to_err_c6", {31'b0, err}, 32'h1);
        chk("to_busy_c6", {31'b0, busy}, 32'h0);
        mem_ready = 1'b1;
        issue(32'h400, 32'h0BADF00D, 2'b10);
        chk("to2_we_c1", {31'b0, mem_we}, 32'h1);
        chk("to2_addr", mem_addr, 32'h400);
        tick(); tick();
        chk("to2_done_c3", {31'b0, done}, 32'h1);
        chk("to2_err_c3", {31'b0, err}, 32'h0);
        tick();

        // Start while busy is ignored; reset during WRITE abandons it
        mem_ready = 1'b0;
        issue(32'h500, 32'h13579BDF, 2'b10);                       // edge 1
        chk("rw_we_c1", {31'b0, mem_we}, 32'h1);
        issue(32'h600, 32'h2468ACE0, 2'b10);                       // edge 2
        chk("rw_addr_hold", mem_addr, 32'h500);
        chk("rw_wdata_hold", mem_wdata, 32'h13579BDF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_rst_we", {31'b0, mem_we}, 32'h0);
        chk("rw_rst_re", {31'b0, mem_re}, 32'h0);
        chk("rw_rst_busy", {31'b0, busy}, 32'h0);
        chk("rw_rst_addr", mem_addr, 32'h0);
        chk("rw_rst_wdata", mem_wdata, 32'h0);
        chk("rw_rst_done", {31'b0, done}, 32'h0);
        chk("rw_rst_err", {31'b0, err}, 32'h0);
        snap_done = done_cnt;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rw_no_extra_done", done_cnt - snap_done, 32'd0);
        chk("rw_idle_busy", {31'b0, busy}, 32'h0);

        chk("never_re_and_we", overlap_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
